// File: rtl/ysyx_25040118_pkg.sv
// Shared encodings for the halt monitor: FSM states and halt causes.
package ysyx_25040118_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_EBREAK   = 2'd1,
      CAUSE_DEADLOOP = 2'd2,
      CAUSE_TIMEOUT  = 2'd3
   } cause_e;

endpackage

// File: rtl/ysyx_25040118_pc_hist.sv
// Ring buffer of recently retired PCs; storage exists only when
// YSYX_25040118_PC_HIST_EN is defined, otherwise the outputs read as zero.
module ysyx_25040118_pc_hist #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned HIST_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_wr_en,
   input  logic [XLEN-1:0]               i_wr_pc,
   input  logic [$clog2(HIST_DEPTH)-1:0] i_rd_idx,
   output logic [XLEN-1:0]               o_rd_pc,
   output logic [$clog2(HIST_DEPTH):0]   o_cnt
);

`ifdef YSYX_25040118_PC_HIST_EN
   localparam int unsigned IW = $clog2(HIST_DEPTH);
   localparam int unsigned CW = IW + 1;

   logic [XLEN-1:0] r_mem [HIST_DEPTH];
   logic [IW-1:0]   r_wptr;
   logic [CW-1:0]   r_cnt;
   logic [IW-1:0]   w_rd_ptr;

   // Write pointer and fill level; contents are deliberately left unreset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr <= '0;
         r_cnt  <= '0;
      end else if (i_wr_en) begin
         r_wptr <= r_wptr + IW'(1);
         if (r_cnt != CW'(HIST_DEPTH)) r_cnt <= r_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[r_wptr] <= i_wr_pc;
   end

   // Depth is a power of two, so the subtraction wraps around the ring.
   assign w_rd_ptr = r_wptr - IW'(1) - i_rd_idx;
   assign o_rd_pc  = ({1'b0, i_rd_idx} < r_cnt) ? r_mem[w_rd_ptr] : '0;
   assign o_cnt    = r_cnt;
`else
   logic w_unused;
   assign w_unused = ^{clk, rst, i_wr_en, i_wr_pc, i_rd_idx};
   assign o_rd_pc  = '0;
   assign o_cnt    = '0;
`endif

endmodule

// File: rtl/ysyx_25040118_halt_mon.sv
// Simulation halt monitor: detects ebreak, same-PC deadloops and cycle timeouts.
// Optional PC history is enabled with YSYX_25040118_PC_HIST_EN.
module ysyx_25040118_halt_mon
   import ysyx_25040118_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned STALL_LIMIT = 100,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MAX_CYCLES  = 0,
   parameter int unsigned HIST_DEPTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          retire,
   input  logic [XLEN-1:0]               pc,
   input  logic                          ebreak,
   input  logic [XLEN-1:0]               code,
   input  logic                          resume,
   input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
   output logic                          stop,
   output logic [1:0]                    halt_cause,
   output logic [XLEN-1:0]               halt_pc,
   output logic [XLEN-1:0]               halt_code,
   output logic [CNT_W-1:0]              cycle_cnt,
   output logic [CNT_W-1:0]              retire_cnt,
   output logic [XLEN-1:0]               hist_pc,
   output logic [$clog2(HIST_DEPTH):0]   hist_cnt
);

   state_e          r_state,     w_state_nxt;
   cause_e          r_cause,     w_cause_nxt;
   logic            r_stop,      w_stop_nxt;
   logic [XLEN-1:0] r_halt_pc,   w_halt_pc_nxt;
   logic [XLEN-1:0] r_halt_code, w_halt_code_nxt;
   logic [XLEN-1:0] r_last_pc,   w_last_pc_nxt;
   logic [CNT_W-1:0] r_cycle,    w_cycle_nxt;
   logic [CNT_W-1:0] r_retire,   w_retire_nxt;
   logic [CNT_W-1:0] r_same,     w_same_nxt;

   logic w_accept;
   logic w_same_pc;
   logic w_ebreak;
   logic w_dead;
   logic w_tmo;

   // Retires are only accepted while not halted; causes can never fire in HALTED.
   assign w_accept  = retire && (r_state != ST_HALTED);
   assign w_same_pc = (pc == r_last_pc);
   assign w_ebreak  = w_accept && ebreak;
   assign w_dead    = w_accept && w_same_pc && (r_same == CNT_W'(STALL_LIMIT - 1));
   assign w_tmo     = (MAX_CYCLES != 0) && (r_state == ST_RUN) &&
                      (r_cycle == CNT_W'(MAX_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cause     <= CAUSE_NONE;
         r_stop      <= 1'b0;
         r_halt_pc   <= '0;
         r_halt_code <= '0;
         r_last_pc   <= '0;
         r_cycle     <= '0;
         r_retire    <= '0;
         r_same      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cause     <= w_cause_nxt;
         r_stop      <= w_stop_nxt;
         r_halt_pc   <= w_halt_pc_nxt;
         r_halt_code <= w_halt_code_nxt;
         r_last_pc   <= w_last_pc_nxt;
         r_cycle     <= w_cycle_nxt;
         r_retire    <= w_retire_nxt;
         r_same      <= w_same_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cause_nxt     = r_cause;
      w_stop_nxt      = r_stop;
      w_halt_pc_nxt   = r_halt_pc;
      w_halt_code_nxt = r_halt_code;
      w_last_pc_nxt   = r_last_pc;
      w_cycle_nxt     = r_cycle;
      w_retire_nxt    = r_retire;
      w_same_nxt      = r_same;

      if (w_accept) begin
         if (r_retire != '1) w_retire_nxt = r_retire + CNT_W'(1);
         if (w_same_pc) begin
            if (r_same != '1) w_same_nxt = r_same + CNT_W'(1);
         end else begin
            w_same_nxt    = '0;
            w_last_pc_nxt = pc;
         end
      end

      case (r_state)
         ST_IDLE: begin
            if (retire) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (r_cycle != '1) w_cycle_nxt = r_cycle + CNT_W'(1);
         end
         ST_HALTED: begin
            if (resume) begin
               w_state_nxt = ST_RUN;
               w_stop_nxt  = 1'b0;
               w_cause_nxt = CAUSE_NONE;
               w_same_nxt  = '0;
               w_cycle_nxt = '0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // Highest-priority cause wins; timeout reports the last distinct PC.
      if (w_ebreak || w_dead || w_tmo) begin
         w_state_nxt = ST_HALTED;
         w_stop_nxt  = 1'b1;
         if (w_ebreak) begin
            w_cause_nxt     = CAUSE_EBREAK;
            w_halt_pc_nxt   = pc;
            w_halt_code_nxt = code;
         end else if (w_dead) begin
            w_cause_nxt   = CAUSE_DEADLOOP;
            w_halt_pc_nxt = pc;
         end else begin
            w_cause_nxt   = CAUSE_TIMEOUT;
            w_halt_pc_nxt = r_last_pc;
         end
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst && (r_state != ST_HALTED) && (w_state_nxt == ST_HALTED))
         $display("[HALT] cause=%0d pc=0x%08x", w_cause_nxt, w_halt_pc_nxt);
   end
`endif

   ysyx_25040118_pc_hist #(
      .XLEN       (XLEN),
      .HIST_DEPTH (HIST_DEPTH)
   ) u_pc_hist (
      .clk      (clk),
      .rst      (rst),
      .i_wr_en  (w_accept),
      .i_wr_pc  (pc),
      .i_rd_idx (hist_idx),
      .o_rd_pc  (hist_pc),
      .o_cnt    (hist_cnt)
   );

   assign stop       = r_stop;
   assign halt_cause = r_cause;
   assign halt_pc    = r_halt_pc;
   assign halt_code  = r_halt_code;
   assign cycle_cnt  = r_cycle;
   assign retire_cnt = r_retire;

endmodule
